// File: rtl/tv_runner.sv
// tv_runner: on-chip test-vector engine. Holds DEPTH {stimulus, expected}
// pairs, drives each stimulus to a small combinational block, waits SETTLE
// cycles, then compares the block's response against the expected value.
// Errors are counted and the first mismatch is captured.
module tv_runner #(
  parameter int IN_W   = 3,
  parameter int OUT_W  = 1,
  parameter int DEPTH  = 8,
  parameter int SETTLE = 1,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1),
  localparam int VW = IN_W + OUT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [VW-1:0]    wr_data,
  input  logic             start,
  input  logic             abort,
  input  logic [CW-1:0]    n_vec,
  output logic [IN_W-1:0]  x_out,
  input  logic [OUT_W-1:0] f_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             aborted,
  output logic [CW-1:0]    err_count,
  output logic             fail_valid,
  output logic [AW-1:0]    fail_idx,
  output logic [OUT_W-1:0] fail_got
);

  // Settle counter needs at least one bit even when SETTLE is 0.
  localparam int SW = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_APPLY = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_CHECK = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  logic [VW-1:0]    mem [DEPTH];
  logic [VW-1:0]    rd_word;

  logic [2:0]       state_q, state_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [CW-1:0]    n_q, n_d;
  logic [SW-1:0]    cnt_q, cnt_d;
  logic [OUT_W-1:0] exp_q, exp_d;
  logic [IN_W-1:0]  x_q, x_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             aborted_q, aborted_d;
  logic [CW-1:0]    err_q, err_d;
  logic             fv_q, fv_d;
  logic [AW-1:0]    fidx_q, fidx_d;
  logic [OUT_W-1:0] fgot_q, fgot_d;

  logic             idle_or_done;
  logic             in_run;
  logic             wr_ok;
  logic [CW-1:0]    n_clamped;

  assign idle_or_done = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign in_run       = (state_q == ST_APPLY) || (state_q == ST_WAIT) || (state_q == ST_CHECK);
  assign wr_ok        = wr_en && idle_or_done && (int'(wr_addr) < DEPTH);
  assign n_clamped    = (n_vec > CW'(DEPTH)) ? CW'(DEPTH) : n_vec;
  // idx never exceeds N-1 <= DEPTH-1, so this read stays in range.
  assign rd_word      = mem[idx_q];

  // Vector store: loaded only between runs, contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_addr] <= wr_data;
  end

  // Sequencer next-state: abort pre-empts any in-flight APPLY/WAIT/CHECK.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    n_d       = n_q;
    cnt_d     = cnt_q;
    exp_d     = exp_q;
    x_d       = x_q;
    busy_d    = busy_q;
    done_d    = done_q;
    pass_d    = pass_q;
    aborted_d = aborted_q;
    err_d     = err_q;
    fv_d      = fv_q;
    fidx_d    = fidx_q;
    fgot_d    = fgot_q;

    if (in_run && abort) begin
      state_d   = ST_DONE;
      busy_d    = 1'b0;
      done_d    = 1'b1;
      aborted_d = 1'b1;
      pass_d    = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            n_d       = n_clamped;
            idx_d     = '0;
            done_d    = 1'b0;
            pass_d    = 1'b0;
            aborted_d = 1'b0;
            err_d     = '0;
            fv_d      = 1'b0;
            fidx_d    = '0;
            fgot_d    = '0;
            if (n_clamped == '0) begin
              // Empty run completes immediately and trivially passes.
              state_d = ST_DONE;
              done_d  = 1'b1;
              pass_d  = 1'b1;
            end else begin
              state_d = ST_APPLY;
              busy_d  = 1'b1;
            end
          end
        end
        ST_APPLY: begin
          x_d     = rd_word[VW-1:OUT_W];
          exp_d   = rd_word[OUT_W-1:0];
          cnt_d   = SW'(SETTLE);
          state_d = (SETTLE == 0) ? ST_CHECK : ST_WAIT;
        end
        ST_WAIT: begin
          cnt_d = cnt_q - SW'(1);
          if (cnt_q == SW'(1)) state_d = ST_CHECK;
        end
        ST_CHECK: begin
          if (f_in != exp_q) begin
            err_d = err_q + CW'(1);
            if (!fv_q) begin
              fv_d   = 1'b1;
              fidx_d = idx_q;
              fgot_d = f_in;
            end
          end
          if (CW'(idx_q) == n_q - CW'(1)) begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_d == '0);
          end else begin
            idx_d   = idx_q + AW'(1);
            state_d = ST_APPLY;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and result registers; reset abandons any run without raising done.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      n_q       <= '0;
      cnt_q     <= '0;
      exp_q     <= '0;
      x_q       <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      aborted_q <= 1'b0;
      err_q     <= '0;
      fv_q      <= 1'b0;
      fidx_q    <= '0;
      fgot_q    <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      n_q       <= n_d;
      cnt_q     <= cnt_d;
      exp_q     <= exp_d;
      x_q       <= x_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      aborted_q <= aborted_d;
      err_q     <= err_d;
      fv_q      <= fv_d;
      fidx_q    <= fidx_d;
      fgot_q    <= fgot_d;
    end
  end

  assign x_out      = x_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign aborted    = aborted_q;
  assign err_count  = err_q;
  assign fail_valid = fv_q;
  assign fail_idx   = fidx_q;
  assign fail_got   = fgot_q;

endmodule

// File: tb/tb_tv_runner.sv
// tb_tv_runner: checks tv_runner against a table-level model of a run.
// Two instances share the load/control inputs: u_dut (SETTLE=1) and
// u_dut3 (SETTLE=3); the block under test is a 3-input majority gate,
// optionally behind a 3-register delay.
`timescale 1ns/1ps
module tb_tv_runner;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [2:0] wr_addr = '0;
  logic [3:0] wr_data = '0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] n_vec = '0;

  logic [2:0] x_out, x_out3;
  logic       f_in, f_in3;
  logic       busy, done, pass, aborted, fail_valid, fail_got;
  logic       busy3, done3, pass3, aborted3, fail_valid3, fail_got3;
  logic [3:0] err_count, err_count3;
  logic [2:0] fail_idx, fail_idx3;

  logic       delayed_mode = 1'b0;
  logic [2:0] p1 = '0;
  logic [2:0] p3 = '0;

  function automatic logic maj(input logic [2:0] s);
    return $countones(s) >= 2;
  endfunction

  // Block under test: majority gate, or the same behind three registers.
  always @(posedge clk) begin
    p1 <= {p1[1:0], maj(x_out)};
    p3 <= {p3[1:0], maj(x_out3)};
  end
  assign f_in  = delayed_mode ? p1[2] : maj(x_out);
  assign f_in3 = p3[2];

  tv_runner #(.IN_W(3), .OUT_W(1), .DEPTH(DEPTH), .SETTLE(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .abort(abort), .n_vec(n_vec), .x_out(x_out), .f_in(f_in),
    .busy(busy), .done(done), .pass(pass), .aborted(aborted), .err_count(err_count),
    .fail_valid(fail_valid), .fail_idx(fail_idx), .fail_got(fail_got)
  );

  tv_runner #(.IN_W(3), .OUT_W(1), .DEPTH(DEPTH), .SETTLE(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .abort(abort), .n_vec(n_vec), .x_out(x_out3), .f_in(f_in3),
    .busy(busy3), .done(done3), .pass(pass3), .aborted(aborted3), .err_count(err_count3),
    .fail_valid(fail_valid3), .fail_idx(fail_idx3), .fail_got(fail_got3)
  );

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [3:0] model_mem [DEPTH];
  logic [2:0] last_x = '0;
  int         e_err, e_fidx, e_fgot, e_lat, lat;
  logic [8:0] res_got, res_exp;

  // Reference: walk the first min(n, DEPTH) table entries in order.
  task automatic model_run(input int n, output int m_err, output int m_fidx,
                           output int m_fgot, output int m_lat);
    int   nn;
    logic got;
    nn = (n > DEPTH) ? DEPTH : n;
    m_err = 0; m_fidx = 0; m_fgot = 0;
    for (int k = 0; k < nn; k++) begin
      got = maj(model_mem[k][3:1]);
      if (got !== model_mem[k][0]) begin
        if (m_err == 0) begin m_fidx = k; m_fgot = int'(got); end
        m_err++;
      end
    end
    m_lat = nn * 3;
    if (nn > 0) last_x = model_mem[nn-1][3:1];
  endtask

  task automatic write_entry(input int a, input logic [3:0] d);
    wr_en = 1'b1; wr_addr = 3'(a); wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
    model_mem[a] = d;
  endtask

  task automatic load_majority(input logic [7:0] inv);
    for (int a = 0; a < DEPTH; a++) write_entry(a, {3'(a), maj(3'(a)) ^ inv[a]});
  endtask

  // Pulse start, then count edges after the accepting edge until done.
  task automatic start_run(input int n, output int l);
    start = 1'b1; n_vec = 4'(n);
    @(negedge clk);
    start = 1'b0;
    l = 0;
    while (done !== 1'b1 && l < 200) begin @(negedge clk); l++; end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n_tests++;
    if ({x_out, busy, done, pass, aborted, err_count, fail_valid, fail_idx, fail_got} !== 16'h0) begin
      n_fail++; $display("FAIL reset_outputs got=%h exp=0000",
        {x_out, busy, done, pass, aborted, err_count, fail_valid, fail_idx, fail_got});
    end
    $display("[TB] reset checked");
  endtask

  task automatic test_all_pass();
    load_majority(8'h00);
    model_run(8, e_err, e_fidx, e_fgot, e_lat);
    start_run(8, lat);
    res_got = {err_count, fail_valid, fail_idx, fail_got};
    res_exp = {4'(e_err), e_err > 0, 3'(e_fidx), 1'(e_fgot)};
    n_tests++; if (lat != e_lat) begin n_fail++; $display("FAIL all_pass_latency got=%0d exp=%0d", lat, e_lat); end
    n_tests++; if (pass !== 1'b1) begin n_fail++; $display("FAIL all_pass_pass got=%b exp=1", pass); end
    n_tests++; if (res_got !== res_exp) begin n_fail++; $display("FAIL all_pass_result got=%h exp=%h", res_got, res_exp); end
    n_tests++; if ({x_out, busy, aborted} !== {last_x, 2'b00}) begin
      n_fail++; $display("FAIL all_pass_xout got=%h exp=%h", {x_out, busy, aborted}, {last_x, 2'b00}); end
    $display("[TB] all_pass lat=%0d err=%0d", lat, err_count);
  endtask

  task automatic test_mismatch();
    load_majority(8'b0010_0100);
    model_run(8, e_err, e_fidx, e_fgot, e_lat);
    start_run(8, lat);
    res_got = {err_count, fail_valid, fail_idx, fail_got};
    res_exp = {4'(e_err), e_err > 0, 3'(e_fidx), 1'(e_fgot)};
    n_tests++; if (lat != e_lat) begin n_fail++; $display("FAIL mismatch_latency got=%0d exp=%0d", lat, e_lat); end
    n_tests++; if (res_got !== res_exp) begin n_fail++; $display("FAIL mismatch_result got=%h exp=%h", res_got, res_exp); end
    n_tests++; if (res_got !== {4'd2, 1'b1, 3'd2, 1'b0}) begin n_fail++; $display("FAIL mismatch_plan got=%h exp=%h", res_got, {4'd2, 1'b1, 3'd2, 1'b0}); end
    n_tests++; if (pass !== 1'b0) begin n_fail++; $display("FAIL mismatch_pass got=%b exp=0", pass); end
    $display("[TB] mismatch err=%0d idx=%0d got=%0d", err_count, fail_idx, fail_got);
  endtask

  task automatic test_n_vec_bounds();
    model_run(0, e_err, e_fidx, e_fgot, e_lat);
    start_run(0, lat);
    n_tests++; if (lat != 0) begin n_fail++; $display("FAIL nvec0_latency got=%0d exp=0", lat); end
    n_tests++; if ({pass, busy, err_count} !== 6'b1_0_0000) begin n_fail++; $display("FAIL nvec0_status got=%b exp=100000", {pass, busy, err_count}); end
    n_tests++; if (x_out !== last_x) begin n_fail++; $display("FAIL nvec0_xout got=%0d exp=%0d", x_out, last_x); end
    model_run(12, e_err, e_fidx, e_fgot, e_lat);
    start_run(12, lat);
    res_got = {err_count, fail_valid, fail_idx, fail_got};
    res_exp = {4'(e_err), e_err > 0, 3'(e_fidx), 1'(e_fgot)};
    n_tests++; if (lat != e_lat) begin n_fail++; $display("FAIL nvec12_latency got=%0d exp=%0d", lat, e_lat); end
    n_tests++; if (x_out !== last_x) begin n_fail++; $display("FAIL nvec12_xout got=%0d exp=%0d", x_out, last_x); end
    n_tests++; if (res_got !== res_exp) begin n_fail++; $display("FAIL nvec12_result got=%h exp=%h", res_got, res_exp); end
    $display("[TB] n_vec bounds lat=%0d x_out=%0d", lat, x_out);
  endtask

  task automatic test_abort();
    load_majority(8'b0000_0010);
    model_run(3, e_err, e_fidx, e_fgot, e_lat);
    last_x = model_mem[3][3:1];
    start = 1'b1; n_vec = 4'd8;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 10; c++) begin
      // Write that would flip entry 4 to a mismatch; must be ignored while busy.
      if (c == 2) begin wr_en = 1'b1; wr_addr = 3'd4; wr_data = 4'b1001; end
      else wr_en = 1'b0;
      @(negedge clk);
    end
    wr_en = 1'b0;
    n_tests++; if ({busy, done} !== 2'b10) begin n_fail++; $display("FAIL abort_prebusy got=%b exp=10", {busy, done}); end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    res_got = {err_count, fail_valid, fail_idx, fail_got};
    res_exp = {4'(e_err), e_err > 0, 3'(e_fidx), 1'(e_fgot)};
    n_tests++; if ({done, aborted, pass, busy} !== 4'b1100) begin n_fail++; $display("FAIL abort_status got=%b exp=1100", {done, aborted, pass, busy}); end
    n_tests++; if (res_got !== res_exp) begin n_fail++; $display("FAIL abort_result got=%h exp=%h", res_got, res_exp); end
    n_tests++; if (x_out !== last_x) begin n_fail++; $display("FAIL abort_xout got=%0d exp=%0d", x_out, last_x); end
    // Rerun with start and abort together: start wins, memory unchanged.
    model_run(8, e_err, e_fidx, e_fgot, e_lat);
    start = 1'b1; abort = 1'b1; n_vec = 4'd8;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 200) begin @(negedge clk); lat++; end
    res_got = {err_count, fail_valid, fail_idx, fail_got};
    res_exp = {4'(e_err), e_err > 0, 3'(e_fidx), 1'(e_fgot)};
    n_tests++; if (lat != e_lat) begin n_fail++; $display("FAIL rerun_latency got=%0d exp=%0d", lat, e_lat); end
    n_tests++; if (res_got !== res_exp) begin n_fail++; $display("FAIL rerun_result got=%h exp=%h", res_got, res_exp); end
    n_tests++; if (aborted !== 1'b0) begin n_fail++; $display("FAIL rerun_aborted got=%b exp=0", aborted); end
    $display("[TB] abort err=%0d rerun err=%0d", e_err, err_count);
  endtask

  task automatic test_back_to_back();
    // start while busy is ignored: run length and results stay those of N=8.
    model_run(8, e_err, e_fidx, e_fgot, e_lat);
    start = 1'b1; n_vec = 4'd8;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 200) begin
      start = (lat == 4);
      n_vec = (lat == 4) ? 4'd2 : 4'd8;
      @(negedge clk); lat++;
    end
    start = 1'b0;
    res_got = {err_count, fail_valid, fail_idx, fail_got};
    res_exp = {4'(e_err), e_err > 0, 3'(e_fidx), 1'(e_fgot)};
    n_tests++; if (lat != e_lat) begin n_fail++; $display("FAIL busy_start_latency got=%0d exp=%0d", lat, e_lat); end
    n_tests++; if (res_got !== res_exp) begin n_fail++; $display("FAIL busy_start_result got=%h exp=%h", res_got, res_exp); end
    // Reset during idx 5 abandons the run.
    start = 1'b1; n_vec = 4'd8;
    @(negedge clk);
    start = 1'b0;
    repeat (16) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    last_x = '0;
    n_tests++;
    if ({x_out, busy, done, pass, aborted, err_count, fail_valid, fail_idx, fail_got} !== 16'h0) begin
      n_fail++; $display("FAIL midrun_reset got=%h exp=0000",
        {x_out, busy, done, pass, aborted, err_count, fail_valid, fail_idx, fail_got});
    end
    repeat (30) @(negedge clk);
    n_tests++; if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL midrun_idle got=%b exp=00", {busy, done}); end
    // Memory survives reset.
    model_run(8, e_err, e_fidx, e_fgot, e_lat);
    start_run(8, lat);
    res_got = {err_count, fail_valid, fail_idx, fail_got};
    res_exp = {4'(e_err), e_err > 0, 3'(e_fidx), 1'(e_fgot)};
    n_tests++; if (res_got !== res_exp) begin n_fail++; $display("FAIL post_reset_result got=%h exp=%h", res_got, res_exp); end
    $display("[TB] back_to_back lat=%0d err=%0d", lat, err_count);
  endtask

  task automatic test_random();
    logic [2:0] s;
    int         n;
    for (int it = 0; it < 20; it++) begin
      for (int a = 0; a < DEPTH; a++) begin
        s = 3'($urandom_range(0, 7));
        write_entry(a, {s, maj(s) ^ ($urandom_range(0, 3) == 0)});
      end
      n = int'($urandom_range(0, 12));
      model_run(n, e_err, e_fidx, e_fgot, e_lat);
      start_run(n, lat);
      res_got = {err_count, fail_valid, fail_idx, fail_got};
      res_exp = {4'(e_err), e_err > 0, 3'(e_fidx), 1'(e_fgot)};
      n_tests++; if (lat != e_lat) begin n_fail++; $display("FAIL rand_latency it=%0d got=%0d exp=%0d", it, lat, e_lat); end
      n_tests++; if (res_got !== res_exp) begin n_fail++; $display("FAIL rand_result it=%0d got=%h exp=%h", it, res_got, res_exp); end
      n_tests++; if ({pass, x_out} !== {e_err == 0, last_x}) begin
        n_fail++; $display("FAIL rand_pass_xout it=%0d got=%h exp=%h", it, {pass, x_out}, {e_err == 0, last_x}); end
      $display("[TB] random it=%0d n=%0d err=%0d lat=%0d", it, n, err_count, lat);
    end
  endtask

  task automatic test_settle();
    int lat1, lat3;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    load_majority(8'h00);
    delayed_mode = 1'b1;
    lat1 = -1; lat3 = -1;
    start = 1'b1; n_vec = 4'd8;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c <= 60; c++) begin
      if (lat1 < 0 && done === 1'b1) lat1 = c;
      if (lat3 < 0 && done3 === 1'b1) lat3 = c;
      @(negedge clk);
    end
    delayed_mode = 1'b0;
    n_tests++; if (lat3 != 40) begin n_fail++; $display("FAIL settle3_latency got=%0d exp=40", lat3); end
    n_tests++; if ({pass3, err_count3} !== 5'b1_0000) begin n_fail++; $display("FAIL settle3_pass got=%b exp=10000", {pass3, err_count3}); end
    n_tests++; if (lat1 != 24) begin n_fail++; $display("FAIL settle1_latency got=%0d exp=24", lat1); end
    n_tests++; if (err_count == 4'd0 || pass !== 1'b0) begin
      n_fail++; $display("FAIL settle1_errors got err=%0d pass=%b exp err>0 pass=0", err_count, pass); end
    $display("[TB] settle lat1=%0d err1=%0d lat3=%0d err3=%0d", lat1, err_count, lat3, err_count3);
  endtask

  initial begin
    test_reset();
    test_all_pass();
    test_mismatch();
    test_n_vec_bounds();
    test_abort();
    test_back_to_back();
    test_random();
    test_settle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/tv_runner.md
Name: tv_runner

Overview:
- Parametrised, synthesisable test-vector engine; replaces bench-only file-driven stimulus loops for small combinational blocks.
- Holds DEPTH stimulus/expected pairs in an internal register file.
- On start, applies each stimulus to the block under test, waits a settle time, compares the response and accumulates results.
- Sits beside the block under test, both on-chip and in simulation; loaded through a simple write port.

Parameters:
- IN_W, 3, stimulus width (width of x_out)
- OUT_W, 1, response width (width of f_in)
- DEPTH, 8, number of vector entries (>=2)
- SETTLE, 1, wait cycles between applying a stimulus and its CHECK cycle (>=0)
- Derived: AW = $clog2(DEPTH); CW = $clog2(DEPTH+1); VW = IN_W+OUT_W

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- wr_en  in  1  write one vector entry
- wr_addr  in  AW  entry index
- wr_data  in  VW  {stimulus[IN_W-1:0], expected[OUT_W-1:0]}; stimulus in the MSBs
- start  in  1  begin run (single-cycle pulse)
- abort  in  1  terminate the current run
- n_vec  in  CW  number of vectors to run, sampled at start
- x_out  out  IN_W  stimulus driven to the block under test (registered)
- f_in  in  OUT_W  response from the block under test
- busy  out  1  run in progress
- done  out  1  run finished; held until next accepted start
- pass  out  1  done & !aborted & err_count==0
- aborted  out  1  last run was ended by abort
- err_count  out  CW  number of mismatching vectors
- fail_valid  out  1  at least one mismatch recorded
- fail_idx  out  AW  index of the first mismatch
- fail_got  out  OUT_W  f_in captured at the first mismatch

Behaviour:
- Decided interface: one clock, clk; reset rst_n is synchronous and active-low.
- Reset (rst_n=0 at a clk edge):
  - state=IDLE.
  - x_out, busy, done, pass, aborted, err_count, fail_valid, fail_idx, fail_got all = 0.
  - Vector memory is not reset.
  - Reset mid-run abandons the run with no done.
- Writes:
  - Honoured in IDLE/DONE only; ignored while busy.
  - mem[wr_addr] <= wr_data; wr_addr >= DEPTH is ignored.
- FSM states: IDLE, APPLY, WAIT, CHECK, DONE.
- IDLE/DONE + start:
  - Latch N = min(n_vec, DEPTH).
  - Clear done, pass, aborted, err_count, fail_*; set idx=0.
  - If N==0: go to DONE next edge with pass=1.
  - Else: busy=1, go to APPLY.
  - start while busy is ignored.
- APPLY (1 cycle):
  - x_out <= mem[idx] stimulus; exp <= mem[idx] expected; settle counter <= SETTLE.
  - Go to WAIT, or straight to CHECK if SETTLE==0.
- WAIT: counter decrements each cycle; at 1 go to CHECK. WAIT lasts exactly SETTLE cycles.
- CHECK (1 cycle):
  - Compare f_in to exp on all OUT_W bits.
  - On mismatch: err_count+1 (max value DEPTH, so no overflow).
  - If the mismatch is the first (fail_valid=0): fail_valid=1, fail_idx=idx, fail_got=f_in.
  - If idx==N-1: go to DONE. Else idx+1 and go to APPLY.
- Per-vector cost is SETTLE+2 cycles. For N>0, done rises N*(SETTLE+2) edges after the edge that accepted start.
- f_in is sampled SETTLE+1 edges after the edge that updated x_out.
- DONE: busy=0, done=1, pass registered. x_out holds the last applied stimulus.
- abort while busy (APPLY/WAIT/CHECK):
  - Go to DONE next edge with aborted=1, pass=0.
  - A CHECK in that same cycle is not counted.
  - abort outside busy is ignored.
- start and abort in the same cycle in IDLE/DONE: start wins; abort is ignored.

Test Plan:
1. Load 8 entries with stimulus 000..111 and expected = 3-input majority; model DUT = majority; SETTLE=1, n_vec=8, start -> done after 24 cycles, pass=1, err_count=0, fail_valid=0.
2. Same, but expected bits of entries 2 and 5 inverted -> err_count=2, fail_valid=1, fail_idx=2, fail_got=0 (majority(010)=0), pass=0.
3. n_vec=0 -> done 1 cycle after start, pass=1, x_out unchanged. n_vec=12 -> clamped to 8: done after 24 cycles, x_out=111.
4. abort during WAIT of idx 3 -> DONE next edge, aborted=1, pass=0, err_count counts idx 0..2 only. wr_en during the run does not change the memory (verified by rerun).
5. rst_n=0 for one edge during idx 5 -> all outputs 0 next cycle, state IDLE; start pulsed while busy is ignored (run length unchanged).
6. SETTLE=3, DUT modelled as a 3-cycle register delay of majority -> pass=1. Same DUT with SETTLE=1 -> err_count>0, proving the sample point is at SETTLE+1 edges.
